// File: rtl/leaf_pkt_pkg.sv
// Shared BFT packet definitions: field widths, bit offsets and the packet layout.
package leaf_pkt_pkg;

  localparam int unsigned PAYLOAD_BITS          = 32;
  localparam int unsigned NUM_LEAF_BITS         = 5;
  localparam int unsigned NUM_PORT_BITS         = 4;
  localparam int unsigned NUM_ADDR_BITS         = 7;
  localparam int unsigned NUM_BRAM_ADDR_BITS    = 7;
  localparam int unsigned FREESPACE_UPDATE_SIZE = 64;
  localparam int unsigned PACKET_BITS =
      1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

  // Bit offsets within a packet, LSB of each field.
  localparam int unsigned PktPayloadLsb = 0;
  localparam int unsigned PktAddrLsb    = PktPayloadLsb + PAYLOAD_BITS;
  localparam int unsigned PktPortLsb    = PktAddrLsb + NUM_ADDR_BITS;
  localparam int unsigned PktLeafLsb    = PktPortLsb + NUM_PORT_BITS;
  localparam int unsigned PktValidBit   = PktLeafLsb + NUM_LEAF_BITS;

  typedef struct packed {
    logic                     valid;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [PAYLOAD_BITS-1:0]  payload;
  } pkt_t;

endpackage

// File: rtl/leaf_out_packetizer_if.sv
// User word stream in, BFT packet stream out, bundled for the packetizer.
interface leaf_out_packetizer_if #(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned PACKET_BITS  = 49
);
  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic                    vld_user2interface;
  logic                    ack_interface2user;
  logic [PACKET_BITS-1:0]  pkt_out;
  logic                    pkt_vld;
  logic                    pkt_rdy;

  // Packetizer side.
  modport slave (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    output ack_interface2user,
    output pkt_out,
    output pkt_vld,
    input  pkt_rdy
  );

  // Environment side: user kernel plus output arbiter.
  modport master (
    output din_leaf_user2interface,
    output vld_user2interface,
    input  ack_interface2user,
    input  pkt_out,
    input  pkt_vld,
    output pkt_rdy
  );
endinterface

// File: rtl/leaf_sync_fifo.sv
// Single-clock FIFO, power-of-2 depth, registered occupancy count.
module leaf_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   count_q, count_d;
  logic             push, pop;

  assign full_o    = (count_q == (AddrW + 1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rptr_q];

  // Occupancy next state from push/pop combination.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AddrW + 1)'(1);
      2'b01:   count_d = count_q - (AddrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; not reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

  // Pointers and count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AddrW'(1);
      if (pop)  rptr_q <= rptr_q + AddrW'(1);
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/leaf_out_packetizer.sv
// Per-output-port packetizer: buffers user words, stamps destination and a
// wrapping remote address, and issues BFT packets against receive-BRAM credits.
module leaf_out_packetizer
  import leaf_pkt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_vld,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  input  logic                     credit_upd,
  output logic                     err_credit_ovf,
  leaf_out_packetizer_if.slave     stream_io
);
  localparam int unsigned CreditW = NUM_BRAM_ADDR_BITS + 1;
  // One extra bit so an update on a full counter cannot wrap before the clamp.
  localparam logic [CreditW:0] CreditMax = (CreditW + 1)'(2 ** NUM_BRAM_ADDR_BITS);
  localparam logic [CreditW:0] CreditUpd = (CreditW + 1)'(FREESPACE_UPDATE_SIZE);

  logic [PAYLOAD_BITS-1:0]  fifo_rdata;
  logic                     fifo_full, fifo_empty;
  logic                     push, load;
  logic [CreditW-1:0]       credit_q, credit_d;
  logic [CreditW:0]         credit_sum;
  logic                     credit_ovf;
  logic [NUM_ADDR_BITS-1:0] addr_q;
  pkt_t                     pkt_q;
  logic                     pkt_vld_q;
  logic                     err_q;

  // ack is held low during reset so no word is taken while state clears.
  assign stream_io.ack_interface2user = !fifo_full && !reset;
  assign push = stream_io.vld_user2interface && stream_io.ack_interface2user;
  assign load = !fifo_empty && cfg_vld && (credit_q != '0) &&
                (!pkt_vld_q || stream_io.pkt_rdy);

  leaf_sync_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (push),
    .wr_data_i (stream_io.din_leaf_user2interface),
    .rd_en_i   (load),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Credit next state: spend one per load, add a block per update, clamp at max.
  always_comb begin
    credit_sum = {1'b0, credit_q};
    if (load)       credit_sum = credit_sum - (CreditW + 1)'(1);
    if (credit_upd) credit_sum = credit_sum + CreditUpd;
    credit_ovf = (credit_sum > CreditMax);
    credit_d   = credit_ovf ? CreditMax[CreditW-1:0] : credit_sum[CreditW-1:0];
  end

  // Output register, address pointer, credit counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_q     <= '0;
      pkt_vld_q <= 1'b0;
      addr_q    <= '0;
      credit_q  <= CreditMax[CreditW-1:0];
      err_q     <= 1'b0;
    end else begin
      credit_q <= credit_d;
      if (credit_ovf) err_q <= 1'b1;
      if (load) begin
        pkt_q.valid   <= 1'b1;
        pkt_q.leaf    <= cfg_dest_leaf;
        pkt_q.port    <= cfg_dest_port;
        pkt_q.addr    <= addr_q;
        pkt_q.payload <= fifo_rdata;
        pkt_vld_q     <= 1'b1;
        addr_q        <= addr_q + NUM_ADDR_BITS'(1);
      end else if (stream_io.pkt_rdy) begin
        pkt_q     <= '0;
        pkt_vld_q <= 1'b0;
      end
    end
  end

  assign stream_io.pkt_out = pkt_q;
  assign stream_io.pkt_vld = pkt_vld_q;
  assign err_credit_ovf    = err_q;
endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Self-checking bench for leaf_out_packetizer: directed steps plus a randomized
// phase, with a scoreboard that predicts packet contents from word order.
module tb_leaf_out_packetizer;
  import leaf_pkt_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     cfg_vld;
  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf;
  logic [NUM_PORT_BITS-1:0] cfg_dest_port;
  logic                     credit_upd;
  logic                     err_credit_ovf;

  leaf_out_packetizer_if bus_if ();

  leaf_out_packetizer dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_vld        (cfg_vld),
    .cfg_dest_leaf  (cfg_dest_leaf),
    .cfg_dest_port  (cfg_dest_port),
    .credit_upd     (credit_upd),
    .err_credit_ovf (err_credit_ovf),
    .stream_io      (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [31:0]              exp_q[$];
  logic [NUM_LEAF_BITS-1:0] exp_leaf;
  logic [NUM_PORT_BITS-1:0] exp_port;
  int                       exp_addr = 0;
  int                       n_xfer   = 0;
  int                       last_addr = -1;
  logic                     stall_prev = 1'b0;
  logic [PACKET_BITS-1:0]   prev_pkt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: sample at negedge, predict each transferred packet.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_addr   = 0;
      n_xfer     = 0;
      last_addr  = -1;
      stall_prev = 1'b0;
      prev_pkt   = '0;
    end else begin
      if (stall_prev) begin
        chk("hold_vld", 64'(bus_if.pkt_vld), 64'd1);
        chk("hold_pkt", 64'(bus_if.pkt_out), 64'(prev_pkt));
      end
      if (!bus_if.pkt_vld) chk("idle_zero", 64'(bus_if.pkt_out), 64'd0);
      if (bus_if.pkt_vld && bus_if.pkt_rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $error("FAIL extra_pkt: observed 0x%0h expected no packet", bus_if.pkt_out);
        end else begin
          pkt_t e;
          e.valid   = 1'b1;
          e.leaf    = exp_leaf;
          e.port    = exp_port;
          e.addr    = NUM_ADDR_BITS'(exp_addr % (2 ** NUM_ADDR_BITS));
          e.payload = exp_q.pop_front();
          chk("pkt", 64'(bus_if.pkt_out), 64'(e));
          last_addr = exp_addr % (2 ** NUM_ADDR_BITS);
          exp_addr++;
          n_xfer++;
        end
      end
      stall_prev = bus_if.pkt_vld && !bus_if.pkt_rdy;
      prev_pkt   = bus_if.pkt_out;
      if (bus_if.vld_user2interface && bus_if.ack_interface2user)
        exp_q.push_back(bus_if.din_leaf_user2interface);
    end
  end

  // Present one word and hold it until accepted; optionally jitter pkt_rdy.
  task automatic push(input logic [31:0] d, input bit rand_rdy);
    int t = 0;
    bus_if.din_leaf_user2interface = d;
    bus_if.vld_user2interface      = 1'b1;
    if (rand_rdy) bus_if.pkt_rdy = 1'($urandom_range(0, 1));
    @(negedge clk);
    while (!bus_if.ack_interface2user && t < 100) begin
      @(posedge clk); #1;
      if (rand_rdy) bus_if.pkt_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      $error("FAIL push_timeout: observed ack=0 expected ack=1 within 100 cycles");
    end else begin
      @(posedge clk); #1;
    end
    bus_if.vld_user2interface = 1'b0;
  endtask

  task automatic drain(input int n);
    bus_if.pkt_rdy = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cfg_vld = 1'b0;
    cfg_dest_leaf = '0;
    cfg_dest_port = '0;
    credit_upd = 1'b0;
    bus_if.din_leaf_user2interface = '0;
    bus_if.vld_user2interface = 1'b0;
    bus_if.pkt_rdy = 1'b0;
    exp_leaf = '0;
    exp_port = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 64'(bus_if.ack_interface2user), 64'd0);
    chk("rst_vld", 64'(bus_if.pkt_vld), 64'd0);
    chk("rst_pkt", 64'(bus_if.pkt_out), 64'd0);
    chk("rst_err", 64'(err_credit_ovf), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ack", 64'(bus_if.ack_interface2user), 64'd1);

    // Basic: three words, latency and field stamping.
    cfg_dest_leaf = 5'd3; cfg_dest_port = 4'd2;
    exp_leaf = 5'd3; exp_port = 4'd2;
    cfg_vld = 1'b1;
    bus_if.pkt_rdy = 1'b1;
    push(32'hA5A5_0001, 1'b0);
    chk("lat_t1_vld", 64'(bus_if.pkt_vld), 64'd0);
    push(32'hA5A5_0002, 1'b0);
    chk("lat_t2_vld", 64'(bus_if.pkt_vld), 64'd1);
    chk("lat_t2_pkt", 64'(bus_if.pkt_out), {15'd0, 1'b1, 5'd3, 4'd2, 7'd0, 32'hA5A5_0001});
    push(32'hA5A5_0003, 1'b0);
    drain(6);
    chk("basic_cnt", 64'(n_xfer), 64'd3);
    chk("basic_left", 64'(exp_q.size()), 64'd0);

    // Random data with jittered backpressure.
    for (int i = 0; i < 60; i++) push($urandom, 1'b1);
    drain(30);
    chk("rand_cnt", 64'(n_xfer), 64'd63);
    chk("rand_left", 64'(exp_q.size()), 64'd0);

    // cfg_vld low blocks loads; new cfg applies once raised.
    cfg_vld = 1'b0;
    for (int i = 0; i < 3; i++) push(32'hC0DE_0000 + 32'(i), 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("cfg_block", 64'(bus_if.pkt_vld), 64'd0);
    end
    cfg_dest_leaf = 5'd7; cfg_dest_port = 4'd9;
    exp_leaf = 5'd7; exp_port = 4'd9;
    cfg_vld = 1'b1;
    drain(8);
    chk("cfg_cnt", 64'(n_xfer), 64'd66);
    chk("cfg_left", 64'(exp_q.size()), 64'd0);

    // Backpressure: one held + eight buffered, then release.
    bus_if.pkt_rdy = 1'b0;
    for (int i = 0; i < 9; i++) push($urandom, 1'b0);
    @(negedge clk);
    chk("bp_ack", 64'(bus_if.ack_interface2user), 64'd0);
    chk("bp_vld", 64'(bus_if.pkt_vld), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_stall_cnt", 64'(n_xfer), 64'd66);
    drain(15);
    chk("bp_cnt", 64'(n_xfer), 64'd75);
    chk("bp_left", 64'(exp_q.size()), 64'd0);
    chk("bp_ack_back", 64'(bus_if.ack_interface2user), 64'd1);

    // Reset mid-stream with a held packet and five buffered words.
    bus_if.pkt_rdy = 1'b0;
    for (int i = 0; i < 6; i++) push($urandom, 1'b0);
    @(negedge clk);
    chk("mid_vld_before", 64'(bus_if.pkt_vld), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_vld", 64'(bus_if.pkt_vld), 64'd0);
    chk("mid_pkt", 64'(bus_if.pkt_out), 64'd0);
    chk("mid_ack", 64'(bus_if.ack_interface2user), 64'd0);
    reset = 1'b0;

    // Credit exhaustion from full credit, then one update.
    bus_if.pkt_rdy = 1'b1;
    for (int i = 0; i < 130; i++) push($urandom, 1'b0);
    drain(10);
    chk("exh_cnt", 64'(n_xfer), 64'd128);
    chk("exh_vld", 64'(bus_if.pkt_vld), 64'd0);
    chk("exh_left", 64'(exp_q.size()), 64'd2);
    chk("exh_last_addr", 64'(last_addr), 64'd127);
    credit_upd = 1'b1;
    @(posedge clk); #1;
    credit_upd = 1'b0;
    drain(6);
    chk("upd_cnt", 64'(n_xfer), 64'd130);
    chk("upd_wrap_addr", 64'(last_addr), 64'd1);
    chk("upd_err", 64'(err_credit_ovf), 64'd0);

    // Load and update together at credit 127: clamp and sticky error.
    pulse_reset();
    bus_if.pkt_rdy = 1'b1;
    push(32'h1111_0001, 1'b0);
    push(32'h1111_0002, 1'b0);
    chk("clamp_err_pre", 64'(err_credit_ovf), 64'd0);
    credit_upd = 1'b1;
    @(posedge clk); #1;
    credit_upd = 1'b0;
    chk("clamp_err", 64'(err_credit_ovf), 64'd1);
    drain(5);
    chk("clamp_sticky", 64'(err_credit_ovf), 64'd1);
    chk("clamp_cnt", 64'(n_xfer), 64'd2);
    for (int i = 0; i < 130; i++) push($urandom, 1'b0);
    drain(10);
    chk("clamp_budget", 64'(n_xfer), 64'd130);
    chk("clamp_vld", 64'(bus_if.pkt_vld), 64'd0);
    pulse_reset();
    chk("err_cleared", 64'(err_credit_ovf), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/leaf_out_packetizer.md
# leaf_out_packetizer

Per-output-port packetizer between a user kernel output stream (32-bit data, vld/ack) and the leaf interface's BFT-side output arbiter. It buffers user words, stamps each one with the configured destination leaf/port and a wrapping remote BRAM address, and emits 49-bit BFT packets. It sends only while it holds credits for free space in the destination's receive BRAM; credits come back in fixed-size freespace updates. One instance per output port; runs on the leaf's network clock.

## Interface
Parameters:
- PAYLOAD_BITS, 32, user word width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, remote address field width
- NUM_BRAM_ADDR_BITS, 7, log2 of destination receive BRAM depth; initial credit = 2^NUM_BRAM_ADDR_BITS
- FREESPACE_UPDATE_SIZE, 64, credits returned per update pulse
- FIFO_DEPTH, 8, local word FIFO depth (power of 2, ≥2)
- PACKET_BITS, 49, = 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS

Ports:
- clk  in  1  network clock; only clock
- reset  in  1  synchronous, active-high
- cfg_vld  in  1  destination configured; no packet loads while low
- cfg_dest_leaf  in  NUM_LEAF_BITS  destination leaf
- cfg_dest_port  in  NUM_PORT_BITS  destination port
- din_leaf_user2interface  in  PAYLOAD_BITS  user word
- vld_user2interface  in  1  user word valid
- ack_interface2user  out  1  FIFO can accept; word taken when vld & ack
- credit_upd  in  1  one-cycle pulse: add FREESPACE_UPDATE_SIZE credits
- pkt_out  out  PACKET_BITS  packet
- pkt_vld  out  1  packet valid
- pkt_rdy  in  1  arbiter accepts; transfer when pkt_vld & pkt_rdy
- err_credit_ovf  out  1  sticky: credit count would exceed initial credit

## Operation
- Packet format: [48]=1 valid, [47:43] dest leaf, [42:39] dest port, [38:32] remote addr, [31:0] payload. pkt_out is all-zero when pkt_vld=0.
- FIFO: write on vld&ack; ack = !full (from registered count, no combinational path from vld). Pointers wrap mod FIFO_DEPTH; simultaneous push and pop when full is not possible (ack=0); when empty, a push is not poppable in the same cycle.
- Output register load condition: FIFO non-empty & cfg_vld & credit>0 & (!pkt_vld | pkt_rdy). On load: pop FIFO, capture cfg fields and addr_ptr, addr_ptr <= addr_ptr+1 (mod 2^NUM_ADDR_BITS, 127→0), credit decrements.
- Credit counter width NUM_BRAM_ADDR_BITS+1, reset 2^NUM_BRAM_ADDR_BITS. Same-cycle load and credit_upd: credit <= credit − 1 + FREESPACE_UPDATE_SIZE. If the result would exceed 2^NUM_BRAM_ADDR_BITS: clamp to it and set err_credit_ovf (cleared only by reset).
- Hold: while pkt_vld & !pkt_rdy, pkt_out stable.
- cfg fields sampled at load only; cfg_vld falling holds the pending packet but blocks new loads.
- Reset mid-operation: FIFO emptied, pending packet dropped, addr_ptr=0, credit reinitialised.

## Timing
- Reset values: ack_interface2user=1 (from the first cycle after reset deasserts; 0 while reset high), pkt_vld=0, pkt_out=0, err_credit_ovf=0.
- Latency: word accepted at edge of cycle t → pkt_vld high in cycle t+2 (FIFO write edge t, output-register load edge t+1), given credit and cfg_vld.
- Throughput: 1 packet/cycle with pkt_rdy held high and credit available.
- Credit of 0: pkt_vld falls after the last transfer; a credit_upd in cycle t allows a load at edge t+1 (pkt_vld in t+2).

## Structure
- Shared package leaf_pkt_pkg: field widths, bit-offset localparams for valid/leaf/port/addr/payload, packet struct typedef; reused by leaf interface and BFT-side code.
- One sub-module: leaf_sync_fifo (single-clock, power-of-2 depth, full/empty/count). Credit counter, addr pointer and output register stay in the top.

## Test plan
- Basic: cfg leaf=3, port=2; push 0xA5A5_0001..0003 with pkt_rdy=1 → three packets, first at t+2, addr 0,1,2, pkt_out[48:32] = {1,5'd3,4'd2,addr}.
- Credit exhaustion: push 130 words, no credit_upd → exactly 128 packets, pkt_vld then low; one credit_upd → next 2 packets issue, addr wrap 127→0 observed.
- Backpressure: pkt_rdy=0 for 20 cycles with continuous vld → pkt_out stable, ack falls after FIFO fills (8 words + 1 held); release → no word lost or duplicated, order preserved.
- cfg_vld=0 with words pushed → no pkt_vld; set cfg_vld=1 → packets stream with current cfg values.
- Simultaneous load and credit_upd at credit=128-1 → credit clamps at 128, err_credit_ovf=1 sticky until reset.
- Reset mid-stream with 5 words buffered and pkt_vld=1 → next cycle pkt_vld=0, pkt_out=0; after reset, first packet carries addr 0 and full credit.
